// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the arbiter state enum, the response-owner tag and address defaults.
package imem_pkg;

    // Byte address that maps to RAM word 0.
    localparam logic [31:0] IMEM_BASE   = 32'h0000_3000;

    // Default RAM word-address width (4096 words).
    localparam int unsigned IMEM_ADDR_W = 12;

    // Owner of the RAM port in the previous cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN_F,
        S_OWN_L,
        S_LOCK_L
    } arb_state_t;

    // Which requester the registered read response belongs to.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_L
    } owner_t;

endpackage

// File: rtl/imem_addr_xlate.sv
// Byte-PC to RAM word-index translation with optional range/alignment fault.
// Ports: addr (byte address in), idx (word index out), fault (address fault out).
// Macro IMEM_ARB_RANGE_CHECK_EN enables the fault check; otherwise fault is 0.
module imem_addr_xlate
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter logic [31:0] BASE   = IMEM_BASE
) (
    input  logic [31:0]       addr,
    output logic [ADDR_W-1:0] idx,
    output logic              fault
);

    logic [31:0] off;
    logic        unused_off;

    // Modular subtraction: addresses below BASE wrap to the top of the RAM.
    assign off = addr - BASE;
    assign idx = off[ADDR_W+1:2];

    // Byte-lane bits and the bits above the RAM window never reach the RAM.
    assign unused_off = ^{off[31:ADDR_W+2], off[1:0]};

`ifdef IMEM_ARB_RANGE_CHECK_EN
    // First byte past the RAM window, computed 33 bits wide so it cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << ADDR_W);

    logic below;
    logic above;
    logic misaligned;

    assign below      = (addr < BASE);
    assign above      = ({1'b0, addr} >= LIMIT);
    assign misaligned = (addr[1:0] != 2'b00);
    assign fault      = below | above | misaligned;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single instruction-RAM port between fetch (F) and loader (L).
// Round-robin arbitration, locked loader bursts capped at BURST_MAX grants,
// fetch stall generation and registered read-response routing.
// Ports: clk/reset (async active-low); f_* fetch side; l_* loader side;
// mem_* RAM port (read data one cycle after mem_en).
// Macro IMEM_ARB_RANGE_CHECK_EN enables address fault detection.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter logic [31:0] BASE      = IMEM_BASE,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_stall,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,

    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned      CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             ptr_l;
    logic             ptr_l_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic [CNT_W-1:0] burst_base;
    logic [CNT_W-1:0] burst_inc;

    logic [ADDR_W-1:0] f_idx;
    logic [ADDR_W-1:0] l_idx;
    logic              f_fault;
    logic              l_fault;

    logic grant_f;
    logic grant_l;
    logic locked;
    logic forced_f;

    owner_t      owner_q;
    logic        err_q;
    logic [31:0] f_rdata_q;
    logic [31:0] l_rdata_q;

    imem_addr_xlate #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) u_xlate_f (
        .addr  (f_addr),
        .idx   (f_idx),
        .fault (f_fault)
    );

    imem_addr_xlate #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) u_xlate_l (
        .addr  (l_addr),
        .idx   (l_idx),
        .fault (l_fault)
    );

    // Grant selection. The lock only holds while L keeps both req and lock
    // up; once the burst counter saturates a waiting F gets one slot.
    always_comb begin
        grant_f  = 1'b0;
        grant_l  = 1'b0;
        locked   = (state == S_LOCK_L) && l_req && l_lock;
        forced_f = locked && f_req && (burst_cnt == CNT_MAX);
        priority case (1'b1)
            locked: begin
                grant_f = forced_f;
                grant_l = ~forced_f;
            end
            (f_req && l_req): begin
                grant_f = ~ptr_l;
                grant_l = ptr_l;
            end
            default: begin
                grant_f = f_req;
                grant_l = l_req;
            end
        endcase
    end

    // Next state, pointer and burst count.
    always_comb begin
        state_nxt  = S_IDLE;
        burst_nxt  = '0;
        ptr_l_nxt  = ptr_l;
        burst_base = (state == S_LOCK_L) ? burst_cnt : '0;
        burst_inc  = (burst_base == CNT_MAX) ? CNT_MAX
                                             : burst_base + CNT_W'(1);
        if (grant_f) begin
            ptr_l_nxt = 1'b1;
        end
        if (grant_l) begin
            ptr_l_nxt = 1'b0;
        end
        priority case (1'b1)
            // Forced F slot inside a held lock: L keeps the lock.
            forced_f: begin
                state_nxt = S_LOCK_L;
            end
            (grant_l && l_lock): begin
                state_nxt = S_LOCK_L;
                burst_nxt = burst_inc;
            end
            grant_l: begin
                state_nxt = S_OWN_L;
            end
            grant_f: begin
                state_nxt = S_OWN_F;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr_l     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr_l     <= ptr_l_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // RAM port. Faulting accesses are still granted but never reach the RAM.
    assign f_gnt     = grant_f;
    assign l_gnt     = grant_l;
    assign f_stall   = f_req & ~grant_f;
    assign mem_en    = (grant_f & ~f_fault) | (grant_l & ~l_fault);
    assign mem_we    = grant_l & l_we & ~l_fault;
    assign mem_addr  = grant_l ? l_idx : f_idx;
    assign mem_wdata = l_wdata;

    // Response tag: writes produce no response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end else if (grant_f) begin
            owner_q <= OWN_F;
            err_q   <= f_fault;
        end else if (grant_l && !l_we) begin
            owner_q <= OWN_L;
            err_q   <= l_fault;
        end else begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
        end
    end

    assign f_rvalid = (owner_q == OWN_F);
    assign l_rvalid = (owner_q == OWN_L);

    // Read data passes straight from the RAM in N+1; the hold registers
    // keep the last delivered word stable between responses.
    assign f_rdata = f_rvalid ? (err_q ? 32'h0 : mem_rdata) : f_rdata_q;
    assign l_rdata = l_rvalid ? (err_q ? 32'h0 : mem_rdata) : l_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            if (f_rvalid) begin
                f_rdata_q <= f_rdata;
            end
            if (l_rvalid) begin
                l_rdata_q <= l_rdata;
            end
        end
    end

`ifdef IMEM_ARB_RANGE_CHECK_EN
    assign f_err = f_rvalid & err_q;
    assign l_err = (l_rvalid & err_q) | (grant_l & l_we & l_fault);
`else
    assign f_err = 1'b0;
    assign l_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter with a behavioural RAM.
// Honours IMEM_ARB_RANGE_CHECK_EN for the address-fault scenario.
module tb_imem_arbiter;

    localparam logic [31:0] TB_BASE = 32'h0000_3000;

    typedef struct {
        bit          is_f;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_stall, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        l_gnt, l_rvalid, l_err;
    logic [31:0] l_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram    [0:4095];
    logic [31:0] shadow [0:4095];

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t e;
    logic [33:0] got, want;

    imem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_stall   (f_stall),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_err     (f_err),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_lock    (l_lock),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .l_err     (l_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    function automatic logic [31:0] pat(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] waddr(int i);
        return TB_BASE + 32'(4 * i);
    endfunction

    task automatic idle_inputs();
        f_req  = 1'b0;
        l_req  = 1'b0;
        l_we   = 1'b0;
        l_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if ({f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err,
             mem_en, mem_we, f_stall} !== 9'b0)
            $display("FAIL reset_strobes got=%b want=0",
                     {f_gnt, l_gnt, f_rvalid, l_rvalid, f_err, l_err,
                      mem_en, mem_we, f_stall});
        else n_pass++;
        n_total++;
        if ({f_rdata, l_rdata} !== 64'h0)
            $display("FAIL reset_rdata got=%h want=0", {f_rdata, l_rdata});
        else n_pass++;
    endtask

    task automatic test_f_only();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (i < 2) begin
                f_req  = 1'b1;
                f_addr = waddr(i);
                sb.push_back('{1'b1, shadow[i], 1'b0});
            end
            @(negedge clk);
            n_total++;
            if ({f_gnt, l_gnt, f_stall, mem_en, mem_we} !==
                ((i < 2) ? 5'b10010 : 5'b00000))
                $display("FAIL f_only_gnt cyc=%0d got=%b", i,
                         {f_gnt, l_gnt, f_stall, mem_en, mem_we});
            else n_pass++;
            if (i < 2) begin
                n_total++;
                if (mem_addr !== 12'(i))
                    $display("FAIL f_only_addr got=%h want=%h", mem_addr, 12'(i));
                else n_pass++;
            end
            if (f_rvalid || l_rvalid) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL f_only_resp unexpected rvalid");
                else begin
                    e    = sb.pop_front();
                    got  = e.is_f ? {f_rvalid, f_err, f_rdata} : {l_rvalid, l_err, l_rdata};
                    want = {1'b1, e.err, e.data};
                    if (got !== want) $display("FAIL f_only_resp got=%h want=%h", got, want);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL f_only_drain got=%0d want=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (i < 6) begin
                f_req  = 1'b1;
                l_req  = 1'b1;
                f_addr = waddr(8 + i);
                l_addr = waddr(32 + i);
                if (i % 2 == 0) sb.push_back('{1'b1, shadow[8 + i], 1'b0});
                else            sb.push_back('{1'b0, shadow[32 + i], 1'b0});
            end
            @(negedge clk);
            if (i < 6) begin
                n_total++;
                if ({f_gnt, l_gnt, f_stall} !== ((i % 2 == 0) ? 3'b100 : 3'b011))
                    $display("FAIL alt_gnt cyc=%0d got=%b", i, {f_gnt, l_gnt, f_stall});
                else n_pass++;
                n_total++;
                if (mem_addr !== 12'((i % 2 == 0) ? 8 + i : 32 + i))
                    $display("FAIL alt_addr cyc=%0d got=%h", i, mem_addr);
                else n_pass++;
            end
            if (f_rvalid || l_rvalid) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL alt_resp unexpected rvalid");
                else begin
                    e    = sb.pop_front();
                    got  = e.is_f ? {f_rvalid, f_err, f_rdata} : {l_rvalid, l_err, l_rdata};
                    want = {1'b1, e.err, e.data};
                    if (got !== want) $display("FAIL alt_resp got=%h want=%h", got, want);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL alt_drain got=%0d want=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_lock_burst();
        bit exp_f;
        int exp_idx;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            exp_f   = (i == 16) || (i == 20);
            exp_idx = exp_f ? 4 : 64 + i;
            if (i == 0) begin
                l_req   = 1'b1;
                l_we    = 1'b1;
                l_lock  = 1'b1;
                l_addr  = 32'h0000_3010;
                l_wdata = 32'hDEAD_BEEF;
                shadow[4] = 32'hDEAD_BEEF;
                exp_idx = 4;
            end else if (i < 20) begin
                l_req  = 1'b1;
                l_lock = 1'b1;
                l_addr = waddr(64 + i);
                f_req  = 1'b1;
                f_addr = 32'h0000_3010;
                sb.push_back('{exp_f, shadow[exp_idx], 1'b0});
            end else if (i == 20) begin
                f_req  = 1'b1;
                f_addr = 32'h0000_3010;
                sb.push_back('{1'b1, shadow[4], 1'b0});
            end
            @(negedge clk);
            if (i < 21) begin
                n_total++;
                if ({f_gnt, l_gnt, f_stall, mem_we} !==
                    {exp_f, ~exp_f, (i > 0) && !exp_f, i == 0})
                    $display("FAIL lock_gnt cyc=%0d got=%b", i,
                             {f_gnt, l_gnt, f_stall, mem_we});
                else n_pass++;
                n_total++;
                if (mem_addr !== 12'(exp_idx))
                    $display("FAIL lock_addr cyc=%0d got=%h want=%h", i, mem_addr, 12'(exp_idx));
                else n_pass++;
            end
            if (f_rvalid || l_rvalid) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL lock_resp unexpected rvalid");
                else begin
                    e    = sb.pop_front();
                    got  = e.is_f ? {f_rvalid, f_err, f_rdata} : {l_rvalid, l_err, l_rdata};
                    want = {1'b1, e.err, e.data};
                    if (got !== want) $display("FAIL lock_resp got=%h want=%h", got, want);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL lock_drain got=%0d want=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_range();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (i == 0) begin
                f_req  = 1'b1;
                f_addr = 32'h0000_2FFC;
`ifdef IMEM_ARB_RANGE_CHECK_EN
                sb.push_back('{1'b1, 32'h0, 1'b1});
`else
                sb.push_back('{1'b1, shadow[12'hFFF], 1'b0});
`endif
            end else if (i == 1) begin
                f_req  = 1'b1;
                f_addr = 32'h0000_3002;
`ifdef IMEM_ARB_RANGE_CHECK_EN
                sb.push_back('{1'b1, 32'h0, 1'b1});
`else
                sb.push_back('{1'b1, shadow[0], 1'b0});
`endif
            end else if (i == 2) begin
                l_req   = 1'b1;
                l_we    = 1'b1;
                l_addr  = 32'h0000_2000;
                l_wdata = 32'h1234_5678;
`ifndef IMEM_ARB_RANGE_CHECK_EN
                shadow[12'hC00] = 32'h1234_5678;
`endif
            end
            @(negedge clk);
`ifdef IMEM_ARB_RANGE_CHECK_EN
            if (i < 2) begin
                n_total++;
                if ({f_gnt, mem_en} !== 2'b10)
                    $display("FAIL range_f cyc=%0d got=%b want=10", i, {f_gnt, mem_en});
                else n_pass++;
            end else if (i == 2) begin
                n_total++;
                if ({l_gnt, l_err, mem_en, mem_we} !== 4'b1100)
                    $display("FAIL range_lw got=%b want=1100", {l_gnt, l_err, mem_en, mem_we});
                else n_pass++;
            end
`else
            if (i < 2) begin
                n_total++;
                if ({f_gnt, mem_en, mem_addr} !== {2'b11, (i == 0) ? 12'hFFF : 12'h000})
                    $display("FAIL range_f cyc=%0d got=%b/%h", i, {f_gnt, mem_en}, mem_addr);
                else n_pass++;
            end else if (i == 2) begin
                n_total++;
                if ({l_gnt, l_err, mem_en, mem_we, mem_addr} !== {4'b1011, 12'hC00})
                    $display("FAIL range_lw got=%b/%h", {l_gnt, l_err, mem_en, mem_we}, mem_addr);
                else n_pass++;
            end
`endif
            if (f_rvalid || l_rvalid) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL range_resp unexpected rvalid");
                else begin
                    e    = sb.pop_front();
                    got  = e.is_f ? {f_rvalid, f_err, f_rdata} : {l_rvalid, l_err, l_rdata};
                    want = {1'b1, e.err, e.data};
                    if (got !== want) $display("FAIL range_resp got=%h want=%h", got, want);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL range_drain got=%0d want=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        @(posedge clk);
        #1;
        l_req  = 1'b1;
        l_addr = waddr(8);
        @(negedge clk);
        n_total++;
        if ({f_gnt, l_gnt} !== 2'b01)
            $display("FAIL midrst_gnt got=%b want=01", {f_gnt, l_gnt});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        #2 reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({f_rvalid, l_rvalid} !== 2'b00)
            $display("FAIL midrst_rvalid got=%b want=00", {f_rvalid, l_rvalid});
        else n_pass++;
        @(posedge clk);
        #1;
        f_req  = 1'b1;
        l_req  = 1'b1;
        f_addr = waddr(1);
        @(negedge clk);
        n_total++;
        if ({f_gnt, l_gnt, l_rvalid} !== 3'b100)
            $display("FAIL midrst_next got=%b want=100", {f_gnt, l_gnt, l_rvalid});
        else n_pass++;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]    = pat(i);
            shadow[i] = pat(i);
        end
        test_reset();
        test_f_only();
        test_alternate();
        test_lock_burst();
        test_range();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for the single-port instruction memory behind the fetch unit. Shares one synchronous RAM port between the fetch path (requester F) and a program-loader/debug port (requester L), translating byte PCs based at 0x0000_3000 into word indices. Also generates the fetch-stall used to hold the PC register. Sits between the fetch unit, the loader, and the instruction RAM macro.

## Interface
- `ADDR_W`, 12: RAM word-address width (4096 words).
- `BASE`, 32'h0000_3000: byte address mapped to RAM word 0.
- `BURST_MAX`, 16: maximum consecutive locked L grants before F is forced in.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req` in 1: fetch read request.
- `f_addr` in 32: fetch byte address (PC).
- `f_gnt` out 1: F access issued this cycle.
- `f_stall` out 1: `f_req & ~f_gnt`; PC-register enable is low while set.
- `f_rvalid` out 1: F read data valid.
- `f_rdata` out 32: F read data.
- `f_err` out 1: F address fault; qualified by `f_rvalid`.
- `l_req` in 1: loader request.
- `l_we` in 1: 1 = write, 0 = read.
- `l_lock` in 1: hold ownership for a burst.
- `l_addr` in 32: loader byte address.
- `l_wdata` in 32: write data.
- `l_gnt` out 1: L access issued this cycle.
- `l_rvalid` out 1: L read data valid (reads only).
- `l_rdata` out 32: L read data.
- `l_err` out 1: L address fault; qualified by `l_rvalid`, or by `l_gnt` for writes.
- `mem_en`, `mem_we` out 1: RAM port strobes.
- `mem_addr` out ADDR_W: RAM word index.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, one cycle after `mem_en`.

## Operation
- **Address translation.** Word index is `(addr - BASE)[ADDR_W+1:2]`, using 32-bit modular subtraction.
- **States:** IDLE, OWN_F, OWN_L, LOCK_L. The state records the owner of the previous cycle.
- **Arbitration** is combinational on the current requests and the registered state/pointer. At most one grant per cycle.
- **Single request.** The requester is granted immediately.
- **Both requesting, not locked.** A round-robin pointer selects the winner. After each grant, the pointer switches to the other requester.
- **Reset pointer.** Favours F.
- **Locking.** An L grant with `l_lock=1` enters LOCK_L. In LOCK_L, L wins every cycle while `l_req & l_lock`, even if F is requesting.
  - `burst_cnt` counts locked grants.
  - When `burst_cnt == BURST_MAX` and `f_req` is high, F gets exactly one grant, `burst_cnt` clears, and the state returns to LOCK_L if the lock is still held.
- **Lock release.** Dropping `l_lock` or `l_req` exits to IDLE or OWN_F the same cycle.
- **No request** → IDLE, with `mem_en=0`.
- **Writes** complete on the grant cycle. No `l_rvalid` for writes.

## Timing
- **Grant to response.** Grant and `mem_en` occur in cycle N. `*_rvalid`/`*_rdata` appear in cycle N+1, registered from the owner tag.
- **Back-to-back** grants alternate owners at full throughput (one access per cycle).
- **Worst-case F wait:** `BURST_MAX` cycles while locked, 1 cycle otherwise.
- **Reset values:** state IDLE, pointer F, `burst_cnt`=0, all `*_gnt`/`*_rvalid`/`*_err`/`mem_en`/`mem_we`=0, read-data registers 0.
- **Reset asserted mid-access.** The pending response is discarded; no `rvalid` is produced after reset deassertion.
- **`f_req` dropped with response outstanding.** The response is still delivered in N+1.

## Configuration
- Macro: `IMEM_ARB_RANGE_CHECK_EN`.
- **Defined:** an address below `BASE`, at or above `BASE + 4*2**ADDR_W`, or with `addr[1:0]!=0` is a fault.
  - The requester is still granted, but `mem_en` stays 0.
  - Reads: `*_rvalid`=1, `*_err`=1, `*_rdata`=0 in N+1.
  - Faulting writes: `l_err`=1 with `l_gnt`, and the write is dropped.
- **Undefined:** no checks. The index wraps modulo `2**ADDR_W`, low bits are ignored, and `*_err` is tied to 0.

## Structure
- Package `imem_pkg`: state enum, `IMEM_BASE`, default `ADDR_W`, owner-tag enum {OWN_NONE, OWN_F, OWN_L}.
- Sub-module `imem_addr_xlate`: combinational index plus fault flag; instantiated once per requester.

## Test plan
- **Reset, F only.** `f_addr` 0x3000, 0x3004 on consecutive cycles → `f_gnt`=1 both cycles; `mem_addr` 0, 1; `f_rvalid` one cycle later with matching data; `f_stall`=0.
- **Both requesting 6 cycles, unlocked** → grants F, L, F, L, F, L; `f_stall`=1 on cycles 2, 4, 6.
- **Locked burst.** `l_lock`=1 for 20 cycles with `BURST_MAX`=16, `f_req` held → 16 L grants, 1 F grant, then L resumes. An L write of 0xDEADBEEF at 0x3010 is read back by F as 0xDEADBEEF.
- **Range check, macro defined.** F reads 0x2FFC, then 0x3002 → `mem_en`=0, `f_rvalid`=1, `f_err`=1, `f_rdata`=0 for both. Same stimulus with the macro undefined → `mem_addr` 0xFFF, then 0x000, and `f_err`=0.
- **Mid-access reset.** L read granted, `reset` pulsed low before the next edge → no `l_rvalid`; state IDLE; next simultaneous request grants F.
